binary_search_4bit: RTL and testbench

BINARY_SEARCH_4BIT -- requirements
Module: binary_search_4bit

---
 rtl/binary_search_4bit_if.sv | 23 ++
 rtl/binary_search_4bit.sv | 127 ++++++++++++
 tb/tb_binary_search_4bit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/binary_search_4bit_if.sv
// rtl/binary_search_4bit_if.sv - start/comparator/result signal bundle for binary_search_4bit
interface binary_search_4bit_if;
  logic       start;
  logic       gt;
  logic       eq;
  logic       lt;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       error;
  logic [2:0] steps;

  modport master (
    output start, gt, eq, lt,
    input  guess, busy, done, result, error, steps
  );

  modport slave (
    input  start, gt, eq, lt,
    output guess, busy, done, result, error, steps
  );
endinterface

// File: rtl/binary_search_4bit.sv
// rtl/binary_search_4bit.sv - 4-bit binary search against an external comparator
// Optional comparison counter on the steps output: define BINARY_SEARCH_STEPS_EN.
module binary_search_4bit (
  input logic                clk,
  input logic                rst,
  binary_search_4bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] lo;
  logic [4:0] hi;
  logic [3:0] guess_q;
  logic [3:0] result_q;
  logic       error_q;
  logic       busy;
  logic       done;
  logic       range_empty;
  logic [2:0] cmp;

  // hi wraps to 31 after guess 0 goes low; its top bit marks it as negative.
  assign range_empty = hi[4] | (lo > hi);
  assign cmp         = {bus.gt, bus.eq, bus.lt};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DRIVE;
      DRIVE:   state_nxt = range_empty ? DONE : EVAL;
      EVAL:    state_nxt = (cmp == 3'b100 || cmp == 3'b001) ? DRIVE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      DRIVE:   busy = 1'b1;
      EVAL:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo       <= 5'd0;
      hi       <= 5'd15;
      guess_q  <= 4'd0;
      result_q <= 4'd0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            lo       <= 5'd0;
            hi       <= 5'd15;
            result_q <= 4'd0;
            error_q  <= 1'b0;
          end
        end
        DRIVE: begin
          if (range_empty) begin
            error_q <= 1'b1;
          end else begin
            guess_q <= 4'((lo + hi) >> 1);
          end
        end
        EVAL: begin
          case (cmp)
            3'b010:  result_q <= guess_q;
            3'b100:  lo       <= {1'b0, guess_q} + 5'd1;
            3'b001:  hi       <= {1'b0, guess_q} - 5'd1;
            default: error_q  <= 1'b1;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef BINARY_SEARCH_STEPS_EN
  logic [2:0] steps_q;

  // Only a one-hot comparator answer counts as a comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      steps_q <= 3'd0;
    end else if (state == IDLE && bus.start) begin
      steps_q <= 3'd0;
    end else if (state == EVAL && (cmp == 3'b100 || cmp == 3'b010 || cmp == 3'b001)) begin
      steps_q <= steps_q + 3'd1;
    end
  end

  assign bus.steps = steps_q;
`else
  assign bus.steps = 3'd0;
`endif

  assign bus.guess  = guess_q;
  assign bus.result = result_q;
  assign bus.error  = error_q;
  assign bus.busy   = busy;
  assign bus.done   = done;

endmodule

// File: tb/tb_binary_search_4bit.sv
// tb/tb_binary_search_4bit.sv - self-checking bench for binary_search_4bit
module tb_binary_search_4bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // comparator behaviour: ideal against cfg_sec, unless always-gt or overridden at one EVAL
  int         cfg_sec = 0;
  bit         cfg_agt = 1'b0;
  int         cfg_ok  = 0;
  logic [2:0] cfg_oc  = 3'b000;

  binary_search_4bit_if bus ();

  binary_search_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         sec;
    bit         agt;
    int         ok;
    logic [2:0] oc;
    bit         noise;
    int         res;
    int         err;
    int         steps;
    int         done_e;
    logic [19:0] g;
    int         ng;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int steps_exp(input int n);
`ifdef BINARY_SEARCH_STEPS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic logic [2:0] resp(input int sec, input bit agt, input int ok,
                                      input logic [2:0] oc, input int g, input int k);
    if (agt) return 3'b100;
    if (k == ok) return oc;
    if (sec > g) return 3'b100;
    if (sec == g) return 3'b010;
    return 3'b001;
  endfunction

  // Plain-integer binary search over [0,15]; done edge counts the start edge as 1.
  task automatic model(input int sec, input bit agt, input int ok, input logic [2:0] oc,
                       output int res, output int err, output int n, output int done_e,
                       output logic [19:0] g, output int ng);
    int lo, hi, gg;
    bit fin;
    logic [2:0] code;
    lo = 0; hi = 15; n = 0; res = 0; err = 0; done_e = 0; g = '0; ng = 0; fin = 0;
    for (int it = 0; it < 8 && !fin; it++) begin
      if (lo > hi) begin
        err = 1; done_e = 2 * n + 2; fin = 1;
      end else begin
        gg = (lo + hi) / 2;
        g[4*ng +: 4] = 4'(gg);
        ng++;
        code = resp(sec, agt, ok, oc, gg, ng);
        if (code == 3'b010) begin
          res = gg; n++; done_e = 2 * n + 1; fin = 1;
        end else if (code == 3'b100) begin
          lo = gg + 1; n++;
        end else if (code == 3'b001) begin
          hi = gg - 1; n++;
        end else begin
          err = 1; done_e = 2 * ng + 1; fin = 1;
        end
      end
    end
  endtask

  task automatic drive_cmp(input int k);
    logic [2:0] c;
    c = resp(cfg_sec, cfg_agt, cfg_ok, cfg_oc, int'(bus.guess), k);
    {bus.gt, bus.eq, bus.lt} = c;
  endtask

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic run_search(input string name, input vec_t v);
    int done_at, ng, k;
    logic [19:0] obs;
    cfg_sec = v.sec; cfg_agt = v.agt; cfg_ok = v.ok; cfg_oc = v.oc;
    done_at = 0; ng = 0; k = 0; obs = '0;
    bus.start = 1'b1;
    drive_cmp(0);
    for (int e = 1; e <= 40 && done_at == 0; e++) begin
      @(negedge clk);
      bus.start = (v.noise && bus.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (e == 1) check({name, " busy_after_start"}, int'(bus.busy), 1);
      if ((e % 2) == 0 && bus.busy) begin
        k++;
        if (ng < 5) obs[4*ng +: 4] = bus.guess;
        ng++;
      end
      drive_cmp(k);
      if (bus.done) begin
        done_at = e;
        check({name, " result"}, int'(bus.result), v.res);
        check({name, " error"}, int'(bus.error), v.err);
        check({name, " steps"}, int'(bus.steps), steps_exp(v.steps));
        check({name, " busy_in_done"}, int'(bus.busy), 0);
      end
    end
    check({name, " done_edge"}, done_at, v.done_e);
    check({name, " n_guesses"}, ng, v.ng);
    checks++;
    if (obs !== v.g) begin
      errors++;
      $display("FAIL %s guesses actual=%h required=%h", name, obs, v.g);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check({name, " done_one_cycle"}, int'(bus.done), 0);
    check({name, " idle_busy"}, int'(bus.busy), 0);
    check({name, " result_held"}, int'(bus.result), v.res);
    check({name, " error_held"}, int'(bus.error), v.err);
  endtask

  initial begin
    vec_t rv;
    int   r_res, r_err, r_n, r_de, r_ng;
    logic [19:0] r_g;

    //            sec agt ok oc      noise res err steps done guesses     ng
    vecs[0] = '{7,  0,  0, 3'b000, 0,    7,  0,  1,    3,   20'h00007,  1};
    vecs[1] = '{7,  0,  1, 3'b000, 1,    0,  1,  0,    3,   20'h00007,  1};
    vecs[2] = '{15, 0,  0, 3'b000, 0,    15, 0,  5,    11,  20'hFEDB7,  5};
    vecs[3] = '{15, 1,  0, 3'b000, 0,    0,  1,  5,    12,  20'hFEDB7,  5};
    vecs[4] = '{0,  0,  0, 3'b000, 0,    0,  0,  4,    9,   20'h00137,  4};
    vecs[5] = '{0,  0,  3, 3'b111, 1,    0,  1,  2,    7,   20'h00137,  3};

    bus.start = 1'b0;
    {bus.gt, bus.eq, bus.lt} = 3'b000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst guess", int'(bus.guess), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst result", int'(bus.result), 0);
    check("rst error", int'(bus.error), 0);
    check("rst steps", int'(bus.steps), 0);

    bus.start = 1'b1;
    @(negedge clk);
    check("rst_over_start busy", int'(bus.busy), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_search($sformatf("vec%0d", i), vecs[i]);
    end

    // reset during the second EVAL of secret 15
    cfg_sec = 15; cfg_agt = 0; cfg_ok = 0;
    bus.start = 1'b1;
    drive_cmp(0);
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      bus.start = 1'b0;
      drive_cmp(e / 2);
    end
    check("midrst second_guess", int'(bus.guess), 11);
    check("midrst busy_before", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst guess", int'(bus.guess), 0);
    check("midrst busy", int'(bus.busy), 0);
    check("midrst done", int'(bus.done), 0);
    check("midrst result", int'(bus.result), 0);
    check("midrst error", int'(bus.error), 0);
    check("midrst steps", int'(bus.steps), 0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.done || bus.busy) seen++;
      end
      check("midrst quiet", seen, 0);
    end
    run_search("after_rst", vecs[2]);

    for (int t = 0; t < 40; t++) begin
      rv.sec   = $urandom_range(0, 15);
      rv.agt   = ($urandom_range(0, 7) == 0);
      rv.ok    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
      rv.oc    = 3'($urandom_range(0, 7));
      rv.noise = 1'($urandom_range(0, 1));
      model(rv.sec, rv.agt, rv.ok, rv.oc, r_res, r_err, r_n, r_de, r_g, r_ng);
      rv.res = r_res; rv.err = r_err; rv.steps = r_n; rv.done_e = r_de;
      rv.g = r_g; rv.ng = r_ng;
      run_search($sformatf("rnd%0d", t), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
